unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch requester (read-only) and the data-memory requester (load/store) of the 5-stage pipeline.
- Serialises accesses with one transaction outstanding at a time.
- Drives stall_fetch/stall_mem into the hazard logic so the F and M stages hold while their access is pending.
- Data side has priority, with a fairness cap so fetch is never starved.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data word width; byte-enable width = DATA_WIDTH/8.
- MAX_DM_STREAK, 4, max consecutive data grants while fetch waits (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- if_req  in  1  fetch request; held with if_addr until if_valid.
- if_addr  in  ADDR_WIDTH  fetch address.
- if_flush  in  1  pipeline redirect; discard in-flight fetch result.
- if_rdata  out  DATA_WIDTH  fetched word; valid with if_valid.
- if_valid  out  1  one-cycle fetch completion pulse.
- dm_req  in  1  data request; held with payload until dm_valid.
- dm_we  in  1  1=store, 0=load.
- dm_addr  in  ADDR_WIDTH  data address.
- dm_wdata  in  DATA_WIDTH  store data.
- dm_be  in  DATA_WIDTH/8  store byte enables.
- dm_rdata  out  DATA_WIDTH  load data; valid with dm_valid.
- dm_valid  out  1  one-cycle data completion pulse (loads and stores).
- mem_req  out  1  memory request; held until mem_gnt.
- mem_we, mem_addr, mem_wdata, mem_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered memory payload.
- mem_gnt  in  1  memory accepted request this cycle.
- mem_rvalid  in  1  memory response (read data or write ack); exactly one per accepted request.
- mem_rdata  in  DATA_WIDTH  memory read data.
- stall_fetch  out  1  = if_req & ~if_valid.
- stall_mem  out  1  = dm_req & ~dm_valid.

Behaviour:
- Reset (rst_n low, async): state IDLE, owner NONE.
  - Streak counter 0, discard flag 0.
  - All outputs 0, including stall_fetch/stall_mem, which are gated low while rst_n is low.
  - An in-flight memory transaction is abandoned.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request, stay.
  - Otherwise choose an owner:
    - DM if dm_req and (!if_req or streak < MAX_DM_STREAK).
    - Else IF if if_req.
    - Else DM.
  - Register the owner's payload into mem_* (IF: we=0, be=all-ones, wdata=0). Go to ISSUE.
- ISSUE: mem_req=1, payload stable. On mem_gnt, go to WAIT. If mem_gnt and mem_rvalid arrive in the same cycle, go directly to RESP.
- WAIT: mem_req=0. On mem_rvalid, capture mem_rdata and go to RESP.
- RESP (one cycle):
  - Pulse the owner's valid with captured rdata; the other valid stays 0.
  - Next state is always IDLE.
  - No grant is made in RESP, so a requester's stale req is never re-granted.
- Latency: req seen in IDLE at cycle t → mem_req at t+1. With mem_gnt at t+1 and mem_rvalid at t+1+L, valid is at t+2+L.
- Streak counter:
  - Increments on each DM grant made while if_req=1; saturates at MAX_DM_STREAK.
  - Clears on any IF grant, and on a DM grant with if_req=0.
- Flush:
  - if_flush while owner=IF in ISSUE/WAIT sets the discard flag. The transaction still completes on the memory side.
  - In RESP with the discard flag set, if_valid stays 0. The discard flag clears on RESP exit.
  - if_flush in IDLE or RESP has no effect.
  - dm requests are never flushed.
- Simultaneous if_req and dm_req in IDLE: DM wins unless the streak is saturated.
- if_req dropping while owner=IF (redirect without flush) is treated as a flush.
- dm_req must not drop before dm_valid (protocol; assertion in bench).
- rdata outputs hold their last captured value outside valid cycles. The bench checks them only on valid.

Decomposition:
- Package unified_mem_arb_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP}.
  - owner enum {OWN_NONE, OWN_IF, OWN_DM}.
  - Default width constants.
- Sub-module mem_arb_select: combinational owner choice plus the saturating streak-counter register. Inputs: if_req, dm_req, grant strobe. Output: owner.
- Top holds the FSM, payload/rdata registers, discard flag and stall logic.

Test Plan:
- Lone fetch: if_req=1, if_addr=0x100; memory gnt immediate, rvalid 2 cycles later with 0x00500093 → if_valid one pulse at t+4, if_rdata=0x00500093, stall_fetch=1 until that cycle.
- Contention: if_req and dm_req (load 0x2000) rise the same cycle → DM granted first, dm_valid precedes if_valid, and mem_addr shows 0x2000 then 0x104.
- Starvation cap: dm_req held high with back-to-back new requests, if_req=1 throughout, MAX_DM_STREAK=4 → exactly 4 DM grants, then one IF grant, then DM resumes; the counter clears on the IF grant.
- Store ack: dm_we=1, dm_addr=0x3000, dm_wdata=0xDEADBEEF, dm_be=4'b0011; mem_gnt delayed 3 cycles → mem_req held 3 cycles with a stable payload, and dm_valid pulses one cycle after the write-ack rvalid.
- Flush: IF transaction in WAIT, if_flush pulsed → no if_valid; the following fetch to 0x200 completes normally with correct data.
- Reset mid-operation: rst_n low during WAIT → all outputs 0 immediately (async). After release, the same-cycle gnt+rvalid corner completes in RESP with no hang.

Source files
------------

// File: rtl/unified_mem_arb_pkg.sv
// Shared types and default sizes for the unified memory arbiter.
package unified_mem_arb_pkg;

    localparam int unsigned DEF_ADDR_WIDTH    = 32;
    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_MAX_DM_STREAK = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_DM
    } arb_owner_t;

endpackage

// File: rtl/mem_arb_select.sv
// Owner selection for the unified memory arbiter: data side wins unless it
// has already taken MAX_DM_STREAK grants in a row while fetch was waiting.
module mem_arb_select
    import unified_mem_arb_pkg::*;
#(
    parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       if_req,
    input  logic       dm_req,
    input  logic       grant,
    output arb_owner_t owner
);

    localparam int unsigned   SW         = $clog2(MAX_DM_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DM_STREAK);

    logic [SW-1:0] streak;

    // Pick the owner from the current requests and the streak count.
    always_comb begin
        owner = OWN_NONE;
        if (dm_req && (!if_req || (streak < STREAK_MAX))) begin
            owner = OWN_DM;
        end else if (if_req) begin
            owner = OWN_IF;
        end
    end

    // Count data grants taken while fetch waits; any other grant clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else if (grant) begin
            if ((owner == OWN_DM) && if_req) begin
                if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end else begin
                streak <= '0;
            end
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port unified memory arbiter between instruction fetch and data
// memory. One transaction outstanding; F/M stall while their access pends.
module unified_mem_arbiter
    import unified_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned MAX_DM_STREAK = DEF_MAX_DM_STREAK
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_flush,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_be,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_be,
    input  logic                    mem_gnt,
    input  logic                    mem_rvalid,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    stall_fetch,
    output logic                    stall_mem
);

    arb_state_t state;
    arb_owner_t owner_q;
    arb_owner_t sel_owner;
    logic       discard;
    logic       grant;
    logic       flush_hit;
    logic       done;

    mem_arb_select #(
        .MAX_DM_STREAK(MAX_DM_STREAK)
    ) u_select (
        .clk   (clk),
        .rst_n (rst_n),
        .if_req(if_req),
        .dm_req(dm_req),
        .grant (grant),
        .owner (sel_owner)
    );

    // Grant strobe, fetch-abandon detection and memory completion.
    always_comb begin
        grant     = (state == IDLE) && (if_req || dm_req);
        flush_hit = (owner_q == OWN_IF) && (if_flush || !if_req);
        done      = ((state == ISSUE) && mem_gnt && mem_rvalid) ||
                    ((state == WAIT) && mem_rvalid);
    end

    // Stalls follow the requests, forced low while reset is asserted.
    always_comb begin
        stall_fetch = rst_n && if_req && !if_valid;
        stall_mem   = rst_n && dm_req && !dm_valid;
    end

    // Transaction FSM with registered memory payload, responses and valids.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner_q   <= OWN_NONE;
            discard   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant) begin
                        owner_q <= sel_owner;
                        mem_req <= 1'b1;
                        state   <= ISSUE;
                        if (sel_owner == OWN_DM) begin
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_be    <= dm_be;
                        end else begin
                            mem_we    <= 1'b0;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_be    <= '1;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    if (flush_hit) begin
                        discard <= 1'b1;
                    end
                    if ((state == ISSUE) && mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= WAIT;
                    end
                    // A flush in the completing cycle still suppresses the fetch result.
                    if (done) begin
                        state <= RESP;
                        if (owner_q == OWN_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_valid <= 1'b1;
                        end else if (!(discard || flush_hit)) begin
                            if_rdata <= mem_rdata;
                            if_valid <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if_valid <= 1'b0;
                    dm_valid <= 1'b0;
                    discard  <= 1'b0;
                    owner_q  <= OWN_NONE;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Randomized bench for unified_mem_arbiter: random fetch/data requesters and
// a random-latency memory, checked against a transaction-level model.
module tb_unified_mem_arbiter;

    localparam int unsigned MAXS = 4;
    localparam int O_IF = 1;
    localparam int O_DM = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, if_flush, if_valid;
    logic [31:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_valid;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        stall_fetch, stall_mem;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(
        .ADDR_WIDTH   (32),
        .DATA_WIDTH   (32),
        .MAX_DM_STREAK(MAXS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rdata   (if_rdata),
        .if_valid   (if_valid),
        .dm_req     (dm_req),
        .dm_we      (dm_we),
        .dm_addr    (dm_addr),
        .dm_wdata   (dm_wdata),
        .dm_be      (dm_be),
        .dm_rdata   (dm_rdata),
        .dm_valid   (dm_valid),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .stall_fetch(stall_fetch),
        .stall_mem  (stall_mem)
    );

    // Data requester must hold its request until the completion pulse.
    assert property (@(posedge clk) disable iff (!rst_n) $fell(dm_req) |-> dm_valid)
        else $error("dm_req dropped before dm_valid");

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] initval(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[i*8 +: 8] = n[i*8 +: 8];
        end
        return r;
    endfunction

    // responder memory (written through DUT pins) and reference data memory
    logic [31:0] rmem [logic [31:0]];
    logic [31:0] dref [logic [31:0]];

    bit          if_pending, dm_pending;
    bit          txn_active, txn_granted, txn_flushed, txn_we;
    bit          e_gnt, e_rv, exp_ifv, exp_dmv, in_resp, fast_next, did_reset;
    int          txn_owner;
    logic [31:0] txn_addr, txn_wdata, txn_rdata, old;
    logic [3:0]  txn_be;
    int unsigned streak, gnt_wait, lat, cnt;

    initial begin
        rst_n = 1'b0;
        if_req = 0; if_addr = '0; if_flush = 0;
        dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0;
        if_pending = 0; dm_pending = 0; txn_active = 0; txn_granted = 0;
        txn_flushed = 0; streak = 0; fast_next = 0; did_reset = 0;
        cnt = 0; gnt_wait = 0; lat = 0; txn_owner = 0;
        repeat (2) @(posedge clk);
        #1 check("reset_state", |{if_rdata, if_valid, dm_rdata, dm_valid, mem_req, mem_we,
                                  mem_addr, mem_wdata, mem_be, stall_fetch, stall_mem}, 1'b0);
        #4 rst_n = 1'b1;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            // what the memory side did at the edge just taken
            e_gnt = txn_active && !txn_granted && mem_gnt;
            e_rv  = txn_active && (txn_granted || e_gnt) && mem_rvalid;
            if (e_gnt) txn_granted = 1;
            exp_ifv = e_rv && (txn_owner == O_IF) && !txn_flushed;
            exp_dmv = e_rv && (txn_owner == O_DM);
            in_resp = e_rv;
            if (e_rv) txn_active = 0;

            check("if_valid", if_valid, exp_ifv);
            check("dm_valid", dm_valid, exp_dmv);
            check("stall_fetch", stall_fetch, if_req && !exp_ifv);
            check("stall_mem", stall_mem, dm_req && !exp_dmv);
            check("mem_req", mem_req, txn_active && !txn_granted);
            if (txn_active && !txn_granted)
                check("mem_payload", {mem_we, mem_addr, mem_wdata, mem_be},
                      {txn_we, txn_addr, txn_wdata, txn_be});
            if (exp_ifv) begin
                check("if_rdata", if_rdata, initval(txn_addr));
                if_pending = 0;
            end
            if (exp_dmv) begin
                old = dref.exists(txn_addr) ? dref[txn_addr] : initval(txn_addr);
                if (!txn_we) check("dm_rdata", dm_rdata, old);
                else dref[txn_addr] = merge(old, txn_wdata, txn_be);
                dm_pending = 0;
            end

            // asynchronous reset while a transaction waits for its response
            if (!did_reset && cyc > 1500 && txn_active && txn_granted) begin
                did_reset = 1;
                #1 rst_n = 1'b0;
                #1 check("async_reset_outputs", |{if_rdata, if_valid, dm_rdata, dm_valid, mem_req,
                                                  mem_we, mem_addr, mem_wdata, mem_be}, 1'b0);
                if_req = 1; dm_req = 1;
                #1 check("reset_stall_gate", {stall_fetch, stall_mem}, 2'b00);
                if (txn_owner == O_DM && txn_we) begin
                    old = dref.exists(txn_addr) ? dref[txn_addr] : initval(txn_addr);
                    dref[txn_addr] = merge(old, txn_wdata, txn_be);
                end
                txn_active = 0; txn_granted = 0; if_pending = 0; dm_pending = 0; streak = 0;
                if_req = 0; dm_req = 0; if_flush = 0; mem_gnt = 0; mem_rvalid = 0;
                fast_next = 1;
                @(posedge clk);
                #3 rst_n = 1'b1;
                continue;
            end

            // memory responder
            mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
            if (txn_active) begin
                if (!txn_granted) begin
                    if (gnt_wait == 0) begin
                        mem_gnt = 1;
                        old = rmem.exists(mem_addr) ? rmem[mem_addr] : initval(mem_addr);
                        if (mem_we) begin
                            rmem[mem_addr] = merge(old, mem_wdata, mem_be);
                            txn_rdata = $urandom;
                        end else begin
                            txn_rdata = old;
                        end
                        if (lat == 0) begin
                            mem_rvalid = 1; mem_rdata = txn_rdata;
                        end else begin
                            cnt = lat;
                        end
                    end else begin
                        gnt_wait--;
                    end
                end else begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_rvalid = 1; mem_rdata = txn_rdata;
                    end
                end
            end

            // fetch requester with occasional redirect
            if_flush = 0;
            if (if_pending && $urandom_range(0, 15) == 0) begin
                if_flush = 1;
                if_addr  = 32'h100 + 4 * $urandom_range(0, 63);
                if (txn_active && txn_owner == O_IF) txn_flushed = 1;
            end
            if (!if_pending && $urandom_range(0, 9) < 6) begin
                if_pending = 1;
                if_addr    = 32'h100 + 4 * $urandom_range(0, 63);
            end
            if_req = if_pending;

            // data requester, frequently back-to-back
            if (!dm_pending && $urandom_range(0, 9) < 7) begin
                dm_pending = 1;
                dm_we      = 1'($urandom_range(0, 1));
                dm_addr    = 32'h2000 + 4 * $urandom_range(0, 15);
                dm_wdata   = $urandom;
                dm_be      = 4'($urandom_range(0, 15));
            end
            dm_req = dm_pending;

            // arbiter is free at the next edge: model the grant decision
            if (!txn_active && !in_resp && (if_req || dm_req)) begin
                if (dm_req && (!if_req || streak < MAXS)) txn_owner = O_DM;
                else txn_owner = O_IF;
                if (txn_owner == O_DM && if_req) begin
                    if (streak < MAXS) streak++;
                end else begin
                    streak = 0;
                end
                if (txn_owner == O_DM) begin
                    txn_we = dm_we; txn_addr = dm_addr; txn_wdata = dm_wdata; txn_be = dm_be;
                end else begin
                    txn_we = 0; txn_addr = if_addr; txn_wdata = '0; txn_be = 4'hF;
                end
                txn_active = 1; txn_granted = 0; txn_flushed = 0;
                gnt_wait = fast_next ? 0 : $urandom_range(0, 3);
                lat      = fast_next ? 0 : $urandom_range(0, 3);
                fast_next = 0;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
